kernel_rf_loader: RTL and testbench

Write-side sequencer for the four 512x16 kernel register-file macros behind `kernel_rf_control`. It accepts a stream of signed 16-bit weights over a valid/ready handshake and packs every four consecutive words into one write. The four words go to K1..K4 at a shared address, since the four macros share one write address. It also arbitrates the macro chip-enable between weight loading and compute-side reads, and drives `kernel_rf_en`, `kernel_rf_wr_en`, `kernel_rf_wr_addr` and `kernel1..4_rf_wr_data` directly.

---
 rtl/kernel_rf_loader.sv | 112 +++++++++++
 tb/tb_kernel_rf_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/kernel_rf_loader.sv
// rtl/kernel_rf_loader.sv - packs an interleaved weight stream into 4-wide kernel RF writes
// and arbitrates the shared macro chip-enable between loading and compute-side reads.
module kernel_rf_loader #(
  parameter int DW = 16,
  parameter int AW = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW-1:0]        len_m1,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  input  logic                 kernel_rd_en,
  output logic                 busy,
  output logic                 done,
  output logic                 kernel_rf_en,
  output logic                 kernel_rf_wr_en,
  output logic [AW-1:0]        kernel_rf_wr_addr,
  output logic signed [DW-1:0] kernel1_rf_wr_data,
  output logic signed [DW-1:0] kernel2_rf_wr_data,
  output logic signed [DW-1:0] kernel3_rf_wr_data,
  output logic signed [DW-1:0] kernel4_rf_wr_data
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t                state;
  logic [1:0]            lane;
  logic [AW-1:0]         grp;
  logic [AW-1:0]         len_q;
  logic [AW-1:0]         addr;
  logic signed [DW-1:0]  stage0, stage1, stage2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      lane               <= '0;
      grp                <= '0;
      len_q              <= '0;
      addr               <= '0;
      stage0             <= '0;
      stage1             <= '0;
      stage2             <= '0;
      in_ready           <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      kernel_rf_en       <= 1'b1;
      kernel_rf_wr_en    <= 1'b1;
      kernel_rf_wr_addr  <= '0;
      kernel1_rf_wr_data <= '0;
      kernel2_rf_wr_data <= '0;
      kernel3_rf_wr_data <= '0;
      kernel4_rf_wr_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Reads own the macro only while no load is running, including the start cycle.
          kernel_rf_en    <= ~kernel_rd_en;
          kernel_rf_wr_en <= 1'b1;
          if (start) begin
            addr     <= base_addr;
            len_q    <= len_m1;
            lane     <= '0;
            grp      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          kernel_rf_en    <= 1'b1;
          kernel_rf_wr_en <= 1'b1;
          if (in_valid && in_ready) begin
            lane <= lane + 2'd1;
            case (lane)
              2'd0: stage0 <= in_data;
              2'd1: stage1 <= in_data;
              2'd2: stage2 <= in_data;
              default: begin
                kernel1_rf_wr_data <= stage0;
                kernel2_rf_wr_data <= stage1;
                kernel3_rf_wr_data <= stage2;
                kernel4_rf_wr_data <= in_data;
                kernel_rf_wr_addr  <= addr;
                kernel_rf_en       <= 1'b0;
                kernel_rf_wr_en    <= 1'b0;
                addr               <= addr + 1'b1;
                grp                <= grp + 1'b1;
                if (grp == len_q) begin
                  in_ready <= 1'b0;
                  state    <= FLUSH;
                end
              end
            endcase
          end
        end
        FLUSH: begin
          kernel_rf_en    <= 1'b1;
          kernel_rf_wr_en <= 1'b1;
          busy            <= 1'b0;
          done            <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_rf_loader.sv
// tb/tb_kernel_rf_loader.sv - cycle-vector table plus strobe-log sequences for kernel_rf_loader.
module tb_kernel_rf_loader;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, kernel_rd_en;
  logic [8:0]        base_addr, len_m1;
  logic signed [15:0] in_data;
  logic              in_ready, busy, done, kernel_rf_en, kernel_rf_wr_en;
  logic [8:0]        kernel_rf_wr_addr;
  logic signed [15:0] kernel1_rf_wr_data, kernel2_rf_wr_data, kernel3_rf_wr_data, kernel4_rf_wr_data;

  int total = 0;
  int bad = 0;

  kernel_rf_loader #(.DW(16), .AW(9)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len_m1(len_m1),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .kernel_rd_en(kernel_rd_en),
    .busy(busy), .done(done), .kernel_rf_en(kernel_rf_en), .kernel_rf_wr_en(kernel_rf_wr_en),
    .kernel_rf_wr_addr(kernel_rf_wr_addr),
    .kernel1_rf_wr_data(kernel1_rf_wr_data), .kernel2_rf_wr_data(kernel2_rf_wr_data),
    .kernel3_rf_wr_data(kernel3_rf_wr_data), .kernel4_rf_wr_data(kernel4_rf_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start;
    logic [8:0]  base, len;
    logic        valid;
    logic [15:0] data;
    logic        rd;
    logic [4:0]  ctl;   // {in_ready, busy, done, kernel_rf_en, kernel_rf_wr_en}
    logic [8:0]  addr;
    logic [63:0] wdata; // {k1, k2, k3, k4}
  } vec_t;

  function automatic vec_t v(input logic r, input logic s, input int b, input int l,
                             input logic vl, input int d, input logic rd,
                             input logic ir, input logic bs, input logic dn, input logic en,
                             input logic wen, input int a,
                             input int d1, input int d2, input int d3, input int d4);
    vec_t t;
    t.rst = r; t.start = s; t.base = 9'(b); t.len = 9'(l); t.valid = vl;
    t.data = 16'(d); t.rd = rd; t.ctl = {ir, bs, dn, en, wen}; t.addr = 9'(a);
    t.wdata = {16'(d1), 16'(d2), 16'(d3), 16'(d4)};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Strobe log, sampled just after each edge.
  logic [8:0]  log_addr[$];
  logic [63:0] log_data[$];
  logic        prev_strobe = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!kernel_rf_en && !kernel_rf_wr_en) begin
      total++;
      if (prev_strobe) begin
        bad++;
        $display("FAIL strobe_width actual=2+ cycles required=1 cycle");
      end
      log_addr.push_back(kernel_rf_wr_addr);
      log_data.push_back({kernel1_rf_wr_data, kernel2_rf_wr_data, kernel3_rf_wr_data, kernel4_rf_wr_data});
    end
    prev_strobe = !kernel_rf_en && !kernel_rf_wr_en;
  end

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; kernel_rd_en = 1'b0;
    base_addr = '0; len_m1 = '0; in_data = '0;
  endtask

  vec_t vecs[$];

  initial begin
    // rst,st,base,len,val,data,rd | ir,bs,dn,en,wen,addr,k1..k4
    vecs.push_back(v(1,1,7,7,1,'h1234,1, 0,0,0,1,1,0, 0,0,0,0));
    vecs.push_back(v(1,1,3,2,1,'h4321,1, 0,0,0,1,1,0, 0,0,0,0));
    vecs.push_back(v(0,1,0,1,0,0,0,      1,1,0,1,1,0, 0,0,0,0));
    vecs.push_back(v(0,0,0,0,1,1,0,      1,1,0,1,1,0, 0,0,0,0));
    vecs.push_back(v(0,0,0,0,1,2,0,      1,1,0,1,1,0, 0,0,0,0));
    vecs.push_back(v(0,0,0,0,1,3,0,      1,1,0,1,1,0, 0,0,0,0));
    vecs.push_back(v(0,0,0,0,1,4,0,      1,1,0,0,0,0, 1,2,3,4));
    vecs.push_back(v(0,0,0,0,1,5,0,      1,1,0,1,1,0, 1,2,3,4));
    vecs.push_back(v(0,0,0,0,1,6,0,      1,1,0,1,1,0, 1,2,3,4));
    vecs.push_back(v(0,0,0,0,1,7,0,      1,1,0,1,1,0, 1,2,3,4));
    vecs.push_back(v(0,0,0,0,1,8,0,      0,1,0,0,0,1, 5,6,7,8));
    vecs.push_back(v(0,0,0,0,0,0,0,      0,0,1,1,1,1, 5,6,7,8));
    vecs.push_back(v(0,0,0,0,0,0,0,      0,0,0,1,1,1, 5,6,7,8));
    // backpressure: valid 1,0,0,1,1,0,1
    vecs.push_back(v(0,1,5,0,0,0,0,      1,1,0,1,1,1, 5,6,7,8));
    vecs.push_back(v(0,0,0,0,1,-3,0,     1,1,0,1,1,1, 5,6,7,8));
    vecs.push_back(v(0,0,0,0,0,99,0,     1,1,0,1,1,1, 5,6,7,8));
    vecs.push_back(v(0,0,0,0,0,99,0,     1,1,0,1,1,1, 5,6,7,8));
    vecs.push_back(v(0,0,0,0,1,7,0,      1,1,0,1,1,1, 5,6,7,8));
    vecs.push_back(v(0,0,0,0,1,-32768,0, 1,1,0,1,1,1, 5,6,7,8));
    vecs.push_back(v(0,0,0,0,0,99,0,     1,1,0,1,1,1, 5,6,7,8));
    vecs.push_back(v(0,0,0,0,1,32767,0,  0,1,0,0,0,5, -3,7,-32768,32767));
    vecs.push_back(v(0,0,0,0,0,0,0,      0,0,1,1,1,5, -3,7,-32768,32767));
    // idle arbitration, then start+read in the same cycle
    vecs.push_back(v(0,0,0,0,0,0,1,      0,0,0,0,1,5, -3,7,-32768,32767));
    vecs.push_back(v(0,0,0,0,0,0,0,      0,0,0,1,1,5, -3,7,-32768,32767));
    vecs.push_back(v(0,1,0,0,0,0,1,      1,1,0,0,1,5, -3,7,-32768,32767));
    // reads and a second start during LOAD are ignored
    vecs.push_back(v(0,1,100,5,1,10,1,   1,1,0,1,1,5, -3,7,-32768,32767));
    vecs.push_back(v(0,0,0,0,1,11,1,     1,1,0,1,1,5, -3,7,-32768,32767));
    vecs.push_back(v(0,0,0,0,1,12,1,     1,1,0,1,1,5, -3,7,-32768,32767));
    vecs.push_back(v(0,0,0,0,1,13,1,     0,1,0,0,0,0, 10,11,12,13));
    vecs.push_back(v(0,0,0,0,0,0,1,      0,0,1,1,1,0, 10,11,12,13));
    vecs.push_back(v(0,0,0,0,0,0,0,      0,0,0,1,1,0, 10,11,12,13));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; start = vecs[i].start; base_addr = vecs[i].base; len_m1 = vecs[i].len;
      in_valid = vecs[i].valid; in_data = vecs[i].data; kernel_rd_en = vecs[i].rd;
      cyc();
      chk($sformatf("vec%0d_ctl", i), 64'({in_ready, busy, done, kernel_rf_en, kernel_rf_wr_en}), 64'(vecs[i].ctl));
      chk($sformatf("vec%0d_addr", i), 64'(kernel_rf_wr_addr), 64'(vecs[i].addr));
      chk($sformatf("vec%0d_data", i),
          {kernel1_rf_wr_data, kernel2_rf_wr_data, kernel3_rf_wr_data, kernel4_rf_wr_data}, vecs[i].wdata);
    end
    chk("table_strobe_count", 64'(log_addr.size()), 64'd4);

    // Wrap: base 510, four groups
    idle_inputs();
    log_addr.delete(); log_data.delete();
    start = 1'b1; base_addr = 9'd510; len_m1 = 9'd3;
    cyc();
    start = 1'b0;
    for (int n = 0; n < 16; n++) begin
      in_valid = 1'b1; in_data = 16'(100 + n);
      cyc();
    end
    in_valid = 1'b0;
    wait_done("wrap_done");
    chk("wrap_count", 64'(log_addr.size()), 64'd4);
    if (log_addr.size() == 4) begin
      chk("wrap_addr0", 64'(log_addr[0]), 64'd510);
      chk("wrap_addr1", 64'(log_addr[1]), 64'd511);
      chk("wrap_addr2", 64'(log_addr[2]), 64'd0);
      chk("wrap_addr3", 64'(log_addr[3]), 64'd1);
      chk("wrap_data2", log_data[2], {16'd108, 16'd109, 16'd110, 16'd111});
    end

    // Abort after 6 words of a two-group load
    log_addr.delete(); log_data.delete();
    start = 1'b1; base_addr = 9'd0; len_m1 = 9'd1;
    cyc();
    start = 1'b0;
    for (int n = 0; n < 6; n++) begin
      in_valid = 1'b1; in_data = 16'(21 + n);
      cyc();
    end
    in_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_ctl", 64'({in_ready, busy, done, kernel_rf_en, kernel_rf_wr_en}), 64'b00011);
    chk("abort_out", {7'd0, kernel_rf_wr_addr, kernel1_rf_wr_data, kernel2_rf_wr_data,
                      kernel3_rf_wr_data, kernel4_rf_wr_data[15:9]}, 64'd0);
    chk("abort_out_lo", 64'(kernel4_rf_wr_data[8:0]), 64'd0);
    cyc(); cyc();
    chk("abort_count", 64'(log_addr.size()), 64'd1);
    if (log_addr.size() >= 1) begin
      chk("abort_addr", 64'(log_addr[0]), 64'd0);
      chk("abort_data", log_data[0], {16'd21, 16'd22, 16'd23, 16'd24});
    end
    start = 1'b1; base_addr = 9'd0; len_m1 = 9'd0;
    cyc();
    start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      in_valid = 1'b1; in_data = 16'(9 + n);
      cyc();
    end
    in_valid = 1'b0;
    wait_done("reload_done");
    chk("reload_count", 64'(log_addr.size()), 64'd2);
    if (log_addr.size() == 2) begin
      chk("reload_addr", 64'(log_addr[1]), 64'd0);
      chk("reload_data", log_data[1], {16'd9, 16'd10, 16'd11, 16'd12});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
